multicycle_alu: RTL and testbench

Parametrised, registered successor to the datapath's single-cycle ALU. It adds an iterative multiplier and an optional restoring divider behind a start/done handshake. The block sits in the EX stage. Single-cycle ops complete at full throughput; MUL and DIV stall the issuing stage until `Done`. It is intended for multi-cycle and pipelined core variants that need MUL/UDIV without a combinational multiplier array.

---
 rtl/multicycle_alu.sv | 146 ++++++++++++++
 tb/tb_multicycle_alu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Registered EX-stage ALU: single-cycle logic/arith ops plus an iterative shift-add MUL
// and, when MULTICYCLE_ALU_DIV_EN is defined, a restoring unsigned DIV (Start/Ready/Done).
module multicycle_alu #(
  parameter int WIDTH    = 64,
  parameter int MOVSHIFT = 16
) (
  input  logic             Clk,
  input  logic             ResetL,
  input  logic             Start,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             DivByZero
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_OR     = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_PASSB  = 4'b0111;
  localparam logic [3:0] OP_PASSBM = 4'b1000;
  localparam logic [3:0] OP_MUL    = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             accept, is_multi, last_iter;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa_q, opb_q, acc_q;
  logic [WIDTH-1:0] single_res, mul_acc_nxt, iter_res;

  assign Ready     = (state != S_RUN);
  assign Done      = (state == S_DONE);
  assign accept    = Start & Ready;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  always_comb begin
    single_res = '0;
    case (ALUCtrl)
      OP_AND:    single_res = BusA & BusB;
      OP_OR:     single_res = BusA | BusB;
      OP_ADD:    single_res = BusA + BusB;
      OP_SUB:    single_res = BusA - BusB;
      OP_PASSB:  single_res = BusB << MOVSHIFT;
      OP_PASSBM: single_res = BusB;
      default:   single_res = '0;
    endcase
  end

  // Multiplicand shifts left, multiplier shifts right; high product bits fall off.
  assign mul_acc_nxt = acc_q + (opb_q[0] ? opa_q : '0);

`ifdef MULTICYCLE_ALU_DIV_EN
  localparam logic [3:0] OP_DIV = 4'b1010;

  logic             div_q, rem_ge;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;

  assign is_multi = (ALUCtrl == OP_MUL) || (ALUCtrl == OP_DIV);
  // Dividend shifts out of opa_q while quotient bits shift in; divisor 0 yields all-ones.
  assign rem_sh   = {acc_q, opa_q[WIDTH-1]};
  assign rem_ge   = (rem_sh >= {1'b0, opb_q});
  assign rem_nxt  = rem_ge ? WIDTH'(rem_sh - {1'b0, opb_q}) : rem_sh[WIDTH-1:0];
  assign quo_nxt  = {opa_q[WIDTH-2:0], rem_ge};
  assign iter_res = div_q ? quo_nxt : mul_acc_nxt;

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      div_q     <= 1'b0;
      DivByZero <= 1'b0;
    end else if (accept) begin
      div_q <= (ALUCtrl == OP_DIV);
      if (!is_multi) DivByZero <= 1'b0;
    end else if (state == S_RUN && last_iter) begin
      DivByZero <= div_q && (opb_q == '0);
    end
  end
`else
  assign is_multi  = (ALUCtrl == OP_MUL);
  assign iter_res  = mul_acc_nxt;
  assign DivByZero = 1'b0;
`endif

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: if (last_iter) state_nxt = S_DONE;
      default: begin
        if (accept) state_nxt = is_multi ? S_RUN : S_DONE;
        else        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      cnt   <= '0;
      opa_q <= '0;
      opb_q <= '0;
      acc_q <= '0;
      BusW  <= '0;
      Zero  <= 1'b1;
    end else if (accept) begin
      cnt   <= '0;
      opa_q <= BusA;
      opb_q <= BusB;
      acc_q <= '0;
      if (!is_multi) begin
        BusW <= single_res;
        Zero <= (single_res == '0);
      end
    end else if (state == S_RUN) begin
      cnt <= cnt + 1'b1;
`ifdef MULTICYCLE_ALU_DIV_EN
      if (div_q) begin
        acc_q <= rem_nxt;
        opa_q <= quo_nxt;
      end else
`endif
      begin
        acc_q <= mul_acc_nxt;
        opa_q <= opa_q << 1;
        opb_q <= opb_q >> 1;
      end
      if (last_iter) begin
        BusW <= iter_res;
        Zero <= (iter_res == '0);
      end
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: directed cases plus $urandom traffic against an arithmetic model.
module tb_multicycle_alu;
  localparam int W  = 64;
  localparam int MS = 16;
`ifdef MULTICYCLE_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   ctrl = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         ready, done, zero, dbz;
  logic [W-1:0] busw;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(W), .MOVSHIFT(MS)) dut (
    .Clk(clk), .ResetL(rst_n), .Start(start), .ALUCtrl(ctrl), .BusA(a), .BusB(b),
    .Ready(ready), .Done(done), .BusW(busw), .Zero(zero), .DivByZero(dbz)
  );

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0111: return y << MS;
      4'b1000: return y;
      4'b1001: return x * y;
      4'b1010: if (DIV_EN) return (y == 0) ? {W{1'b1}} : x / y;
               else return '0;
      default: return '0;
    endcase
  endfunction

  function automatic bit multi_op(input logic [3:0] op);
    return (op == 4'b1001) || (DIV_EN && op == 4'b1010);
  endfunction

  function automatic logic [3:0] rand_single_op();
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
    while (multi_op(op)) op = 4'($urandom_range(0, 15));
    return op;
  endfunction

  function automatic logic [W-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; ctrl = op; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int rdy_low);
    cyc = 0; rdy_low = 0;
    while (!done && cyc < 4*W) begin
      if (!ready) rdy_low++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (busw !== '0) begin n_fail++; $display("FAIL reset_busw: got %h want 0", busw); end
    n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b want 1", zero); end
    n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", dbz); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] op; logic [W-1:0] x, y, expv;
    issue(4'b0010, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL add_done: got %b want 1", done); end
    n_checks++; if (busw !== 64'd2) begin n_fail++; $display("FAIL add_busw: got %h want 2", busw); end
    n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL add_zero: got %b want 0", zero); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b want 0", done); end
    issue(4'b0110, 64'd7, 64'd7);
    n_checks++; if (busw !== '0 || zero !== 1'b1) begin n_fail++; $display("FAIL sub_zero: got busw=%h zero=%b want 0/1", busw, zero); end
    for (int i = 0; i < 40; i++) begin
      op = rand_single_op(); x = rand64(); y = rand64();
      if ($urandom_range(0, 3) == 0) y = x;
      expv = model(op, x, y);
      issue(op, x, y);
      n_checks++;
      if (done !== 1'b1 || busw !== expv || zero !== (expv == '0) || dbz !== 1'b0) begin
        n_fail++;
        $display("FAIL single_rand op=%b: got done=%b busw=%h zero=%b dbz=%b want 1/%h/%b/0", op, done, busw, zero, dbz, expv, expv == '0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] op; logic [W-1:0] expv;
    @(negedge clk);
    start = 1'b1; ctrl = 4'b0111; a = 64'd0; b = 64'h1234;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b1 || busw !== 64'h1234_0000) begin n_fail++; $display("FAIL passb: got done=%b busw=%h want 1/12340000", done, busw); end
    ctrl = 4'b1000;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b1 || busw !== 64'h1234) begin n_fail++; $display("FAIL passbm_b2b: got done=%b busw=%h want 1/1234", done, busw); end
    for (int i = 0; i < 24; i++) begin
      op = rand_single_op(); ctrl = op; a = rand64(); b = rand64();
      expv = model(op, a, b);
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b1 || busw !== expv || zero !== (expv == '0)) begin
        n_fail++; $display("FAIL b2b_rand %0d op=%b: got done=%b busw=%h want 1/%h", i, op, done, busw, expv);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got done=%b want 0", done); end
  endtask

  task automatic test_mul();
    logic [W-1:0] x, y, expv; int cyc, rl;
    x = 64'h1_0000_0001; y = 64'h1_0000_0003;
    issue(4'b1001, x, y);
    cyc = 0; rl = 0;
    while (!done && cyc < 4*W) begin
      if (!ready) rl++;
      start = (cyc == 10);
      if (cyc == 10) begin ctrl = 4'b0010; a = '1; b = '1; end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    n_checks++; if (cyc !== W) begin n_fail++; $display("FAIL mul_latency: got %0d want %0d", cyc, W); end
    n_checks++; if (rl !== W) begin n_fail++; $display("FAIL mul_ready_low: got %0d want %0d", rl, W); end
    n_checks++; if (busw !== 64'h4_0000_0003 || zero !== 1'b0) begin n_fail++; $display("FAIL mul_dir: got busw=%h zero=%b want 400000003/0", busw, zero); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0 || busw !== 64'h4_0000_0003) begin n_fail++; $display("FAIL mul_ignored_start: got done=%b busw=%h want 0/400000003", done, busw); end
    for (int i = 0; i < 4; i++) begin
      x = rand64(); y = (i == 3) ? '0 : rand64();
      expv = model(4'b1001, x, y);
      issue(4'b1001, x, y);
      wait_done(cyc, rl);
      n_checks++;
      if (cyc !== W || busw !== expv || zero !== (expv == '0)) begin
        n_fail++; $display("FAIL mul_rand %0d: got cyc=%0d busw=%h want %0d/%h", i, cyc, busw, W, expv);
      end
    end
  endtask

  task automatic test_div();
    logic [W-1:0] x, y, expv; int cyc, rl;
    issue(4'b1010, 64'd100, 64'd7);
    wait_done(cyc, rl);
    n_checks++; if (cyc !== W || busw !== 64'd14 || dbz !== 1'b0) begin n_fail++; $display("FAIL div_100_7: got cyc=%0d busw=%h dbz=%b want %0d/e/0", cyc, busw, dbz, W); end
    issue(4'b1010, 64'd9, 64'd0);
    wait_done(cyc, rl);
    n_checks++; if (cyc !== W || busw !== {W{1'b1}} || dbz !== 1'b1) begin n_fail++; $display("FAIL div_by_zero: got cyc=%0d busw=%h dbz=%b want %0d/all-ones/1", cyc, busw, dbz, W); end
    issue(4'b0010, 64'd1, 64'd2);
    n_checks++; if (dbz !== 1'b0 || busw !== 64'd3) begin n_fail++; $display("FAIL div_dbz_clear: got dbz=%b busw=%h want 0/3", dbz, busw); end
    for (int i = 0; i < 4; i++) begin
      x = rand64();
      y = (i < 2) ? W'($urandom_range(1, 1000)) : rand64() >> $urandom_range(0, 40);
      expv = model(4'b1010, x, y);
      issue(4'b1010, x, y);
      wait_done(cyc, rl);
      n_checks++;
      if (cyc !== W || busw !== expv || dbz !== (y == '0)) begin
        n_fail++; $display("FAIL div_rand %0d: got cyc=%0d busw=%h want %0d/%h", i, cyc, busw, W, expv);
      end
    end
  endtask

  task automatic test_undef_op();
    logic [3:0] op;
    op = DIV_EN ? 4'b1111 : 4'b1010;
    issue(4'b0010, 64'd20, 64'd22);
    issue(op, 64'd100, 64'd7);
    n_checks++;
    if (done !== 1'b1 || busw !== '0 || zero !== 1'b1 || dbz !== 1'b0) begin
      n_fail++; $display("FAIL undef_op %b: got done=%b busw=%h zero=%b dbz=%b want 1/0/1/0", op, done, busw, zero, dbz);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen_done;
    issue(4'b0010, 64'd3, 64'd4);
    issue(4'b1001, rand64() | 64'd1, rand64() | 64'd1);
    repeat (29) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1 || busw !== '0 || zero !== 1'b1 || dbz !== 1'b0) begin
      n_fail++; $display("FAIL abort_async: got done=%b ready=%b busw=%h zero=%b dbz=%b want 0/1/0/1/0", done, ready, busw, zero, dbz);
    end
    seen_done = 0;
    repeat (3) begin @(posedge clk); #1; if (done) seen_done++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (W + 4) begin @(posedge clk); #1; if (done) seen_done++; end
    n_checks++; if (seen_done !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", seen_done); end
    issue(4'b0010, 64'd5, 64'd6);
    n_checks++; if (done !== 1'b1 || busw !== 64'd11) begin n_fail++; $display("FAIL post_abort_add: got done=%b busw=%h want 1/b", done, busw); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_mul();
`ifdef MULTICYCLE_ALU_DIV_EN
    test_div();
`endif
    test_undef_op();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
